// File: rtl/lsm_sequencer.sv
// Load-multiple / store-multiple sequencer: freezes decode and walks the register
// mask of an LM/SM, issuing one register transfer per accepted cycle.
module lsm_sequencer #(
  parameter int          NREGS     = 8,
  parameter int          REG_IDX_W = 3,
  parameter int          ADDR_W    = 16,
  parameter logic [3:0]  OPC_LM    = 4'b0110,
  parameter logic [3:0]  OPC_SM    = 4'b0111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          ir,
  input  logic                 ir_valid,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 advance,
  input  logic                 flush,
  output logic                 stall,
  output logic                 mux_control,
  output logic                 xfer_valid,
  output logic                 xfer_is_load,
  output logic [REG_IDX_W-1:0] xfer_reg,
  output logic [ADDR_W-1:0]    xfer_addr,
  output logic                 last,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [NREGS-1:0]  MASK_ONE = NREGS'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [NREGS-1:0]    remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_load_q, is_load_d;

  logic [NREGS-1:0]    mask;
  logic [3:0]          opcode;
  logic                is_lm;
  logic                multi;
  logic [NREGS-1:0]    remaining_rest;
  logic                one_left;

  assign mask   = ir[NREGS-1:0];
  assign opcode = ir[15:12];
  assign is_lm  = (opcode == OPC_LM);

  // x & (x-1) clears the lowest set bit: non-zero means two or more bits set.
  assign multi = ir_valid && (is_lm || (opcode == OPC_SM)) &&
                 ((mask & (mask - MASK_ONE)) != '0);

  assign remaining_rest = remaining_q & (remaining_q - MASK_ONE);
  assign one_left       = (remaining_q != '0) && (remaining_rest == '0);

  generate
    if (NREGS < 12) begin : g_unused
      logic unused_ir_bits;
      assign unused_ir_bits = ^ir[11:NREGS];
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      is_load_q   <= is_load_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    is_load_d   = is_load_q;
    unique case (state_q)
      IDLE: begin
        if (multi && !flush) begin
          state_d     = RUN;
          remaining_d = mask;
          addr_d      = base_addr;
          is_load_d   = is_lm;
        end
      end
      RUN: begin
        if (flush) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (advance) begin
          remaining_d = remaining_rest;
          addr_d      = addr_q + ADDR_ONE;
          if (one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    mux_control  = 1'b0;
    xfer_valid   = 1'b0;
    xfer_is_load = 1'b0;
    xfer_reg     = '0;
    xfer_addr    = '0;
    last         = 1'b0;
    if (state_q == RUN) begin
      busy         = 1'b1;
      mux_control  = 1'b1;
      xfer_valid   = 1'b1;
      xfer_is_load = is_load_q;
      xfer_addr    = addr_q;
      last         = one_left;
      // Descending scan: the lowest set bit is written last and wins.
      for (int i = NREGS - 1; i >= 0; i--) begin
        if (remaining_q[i]) xfer_reg = REG_IDX_W'(i);
      end
    end
    stall = rst && (busy || (multi && !flush));
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed self-checking bench for lsm_sequencer: default 8-register instance
// plus a 12-register instance for the wide-mask case.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir = '0;
  logic        ir_valid = 1'b0;
  logic [15:0] base_addr = '0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;

  logic        stall, mux_control, xfer_valid, xfer_is_load, last, busy;
  logic [2:0]  xfer_reg;
  logic [15:0] xfer_addr;

  logic [15:0] ir2 = '0;
  logic        ir_valid2 = 1'b0;
  logic        advance2 = 1'b0;
  logic        stall2, mux_control2, xfer_valid2, xfer_is_load2, last2, busy2;
  logic [3:0]  xfer_reg2;
  logic [15:0] xfer_addr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsm_sequencer dut (
    .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .base_addr(base_addr),
    .advance(advance), .flush(flush), .stall(stall), .mux_control(mux_control),
    .xfer_valid(xfer_valid), .xfer_is_load(xfer_is_load), .xfer_reg(xfer_reg),
    .xfer_addr(xfer_addr), .last(last), .busy(busy)
  );

  lsm_sequencer #(.NREGS(12), .REG_IDX_W(4)) dut12 (
    .clk(clk), .rst(rst), .ir(ir2), .ir_valid(ir_valid2), .base_addr(base_addr),
    .advance(advance2), .flush(flush), .stall(stall2), .mux_control(mux_control2),
    .xfer_valid(xfer_valid2), .xfer_is_load(xfer_is_load2), .xfer_reg(xfer_reg2),
    .xfer_addr(xfer_addr2), .last(last2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_xfer(input string tag, input int r, input int a, input bit l, input bit ld);
    check({tag, ".valid"}, xfer_valid, 1'b1);
    check({tag, ".busy"},  busy, 1'b1);
    check({tag, ".mux"},   mux_control, 1'b1);
    check({tag, ".stall"}, stall, 1'b1);
    check({tag, ".reg"},   xfer_reg, r);
    check({tag, ".addr"},  xfer_addr, a);
    check({tag, ".last"},  last, l);
    check({tag, ".load"},  xfer_is_load, ld);
  endtask

  task automatic chk_idle(input string tag, input bit st);
    check({tag, ".busy"},  busy, 1'b0);
    check({tag, ".valid"}, xfer_valid, 1'b0);
    check({tag, ".mux"},   mux_control, 1'b0);
    check({tag, ".last"},  last, 1'b0);
    check({tag, ".stall"}, stall, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a multi instruction present: stall must stay forced low.
    ir = 16'h60FF; ir_valid = 1'b1; base_addr = 16'h0100;
    #2;
    chk_idle("rst", 1'b0);
    check("rst.addr", xfer_addr, 16'h0000);
    check("rst.reg", xfer_reg, 3'd0);
    cyc();
    rst = 1'b1; ir_valid = 1'b0;
    #1;
    chk_idle("post_rst", 1'b0);

    // LM 60FF from 0100, advance held high.
    cyc();
    ir = 16'h60FF; ir_valid = 1'b1; base_addr = 16'h0100; advance = 1'b1;
    #1;
    chk_idle("lm8.D", 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      ir_valid = 1'b0;
      #1;
      chk_xfer($sformatf("lm8.x%0d", k), k, 16'h0100 + k, (k == 7), 1'b1);
    end
    cyc();
    #1;
    chk_idle("lm8.end", 1'b0);

    // SM 7085 from 0020 with advance toggling 1,0,1,0,1.
    cyc();
    ir = 16'h7085; ir_valid = 1'b1; base_addr = 16'h0020; advance = 1'b1;
    #1;
    chk_idle("sm.D", 1'b1);
    cyc(); ir_valid = 1'b0; advance = 1'b1; #1;
    chk_xfer("sm.c1", 0, 16'h0020, 1'b0, 1'b0);
    cyc(); advance = 1'b0; #1;
    chk_xfer("sm.c2", 2, 16'h0021, 1'b0, 1'b0);
    cyc(); advance = 1'b1; #1;
    chk_xfer("sm.c3", 2, 16'h0021, 1'b0, 1'b0);
    cyc(); advance = 1'b0; #1;
    chk_xfer("sm.c4", 7, 16'h0022, 1'b1, 1'b0);
    cyc(); advance = 1'b1; #1;
    chk_xfer("sm.c5", 7, 16'h0022, 1'b1, 1'b0);
    cyc(); #1;
    chk_idle("sm.end", 1'b0);

    // Pass-through cases: single bit, empty mask, other opcode, invalid ir.
    ir = 16'h6010; ir_valid = 1'b1; #1;
    chk_idle("single.D", 1'b0);
    cyc(); ir = 16'h6000; #1;
    chk_idle("single.next", 1'b0);
    cyc(); ir = 16'h30FF; #1;
    chk_idle("empty.next", 1'b0);
    cyc(); ir = 16'h60FF; ir_valid = 1'b0; #1;
    chk_idle("other.next", 1'b0);
    cyc(); #1;
    chk_idle("invalid.next", 1'b0);

    // Address wrap: mask 07 from FFFE.
    ir = 16'h6007; ir_valid = 1'b1; base_addr = 16'hFFFE; advance = 1'b1; #1;
    check("wrap.D.stall", stall, 1'b1);
    cyc(); ir_valid = 1'b0; #1;
    chk_xfer("wrap.x0", 0, 16'hFFFE, 1'b0, 1'b1);
    cyc(); #1;
    chk_xfer("wrap.x1", 1, 16'hFFFF, 1'b0, 1'b1);
    cyc(); #1;
    chk_xfer("wrap.x2", 2, 16'h0000, 1'b1, 1'b1);
    cyc(); #1;
    chk_idle("wrap.end", 1'b0);

    // Flush on the third transfer of an FF mask.
    ir = 16'h60FF; ir_valid = 1'b1; base_addr = 16'h0000; #1;
    cyc(); ir_valid = 1'b0; #1;
    chk_xfer("fl.x0", 0, 16'h0000, 1'b0, 1'b1);
    cyc(); #1;
    chk_xfer("fl.x1", 1, 16'h0001, 1'b0, 1'b1);
    cyc(); flush = 1'b1; #1;
    chk_xfer("fl.x2", 2, 16'h0002, 1'b0, 1'b1);
    cyc(); flush = 1'b0; #1;
    chk_idle("fl.after", 1'b0);
    cyc(); #1;
    chk_idle("fl.after2", 1'b0);

    // Flush in IDLE masks stall and blocks entry.
    ir_valid = 1'b1; flush = 1'b1; #1;
    chk_idle("flidle.D", 1'b0);
    cyc(); ir_valid = 1'b0; flush = 1'b0; #1;
    chk_idle("flidle.next", 1'b0);

    // Asynchronous reset mid-sequence.
    ir_valid = 1'b1; base_addr = 16'h0040; #1;
    cyc(); ir_valid = 1'b0; #1;
    chk_xfer("rs.x0", 0, 16'h0040, 1'b0, 1'b1);
    cyc(); #1;
    chk_xfer("rs.x1", 1, 16'h0041, 1'b0, 1'b1);
    rst = 1'b0; ir_valid = 1'b1; #1;
    chk_idle("rs.low", 1'b0);
    check("rs.low.addr", xfer_addr, 16'h0000);
    check("rs.low.reg", xfer_reg, 3'd0);
    check("rs.low.load", xfer_is_load, 1'b0);
    cyc(); rst = 1'b1; ir_valid = 1'b0; #1;
    chk_idle("rs.release", 1'b0);

    // Back-to-back: LM 6003 then SM 7006 accepted the first cycle back in IDLE.
    cyc(); ir = 16'h6003; ir_valid = 1'b1; base_addr = 16'h0010; #1;
    check("b2b.D.stall", stall, 1'b1);
    cyc(); ir = 16'h7006; base_addr = 16'h0050; #1;
    chk_xfer("b2b.a0", 0, 16'h0010, 1'b0, 1'b1);
    cyc(); #1;
    chk_xfer("b2b.a1", 1, 16'h0011, 1'b1, 1'b1);
    cyc(); #1;
    chk_idle("b2b.D2", 1'b1);
    cyc(); ir_valid = 1'b0; #1;
    chk_xfer("b2b.b0", 1, 16'h0050, 1'b0, 1'b0);
    cyc(); #1;
    chk_xfer("b2b.b1", 2, 16'h0051, 1'b1, 1'b0);
    cyc(); #1;
    chk_idle("b2b.end", 1'b0);

    // 12-register instance: mask 801 gives regs 0 and 11.
    ir2 = 16'h6801; ir_valid2 = 1'b1; advance2 = 1'b1; base_addr = 16'h0200; #1;
    check("w12.D.stall", stall2, 1'b1);
    check("w12.D.busy", busy2, 1'b0);
    cyc(); ir_valid2 = 1'b0; #1;
    check("w12.x0.valid", xfer_valid2, 1'b1);
    check("w12.x0.reg", xfer_reg2, 4'd0);
    check("w12.x0.addr", xfer_addr2, 16'h0200);
    check("w12.x0.last", last2, 1'b0);
    cyc(); #1;
    check("w12.x1.valid", xfer_valid2, 1'b1);
    check("w12.x1.reg", xfer_reg2, 4'd11);
    check("w12.x1.addr", xfer_addr2, 16'h0201);
    check("w12.x1.last", last2, 1'b1);
    cyc(); #1;
    check("w12.end.busy", busy2, 1'b0);
    check("w12.end.valid", xfer_valid2, 1'b0);
    check("w12.end.stall", stall2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsm_sequencer.md
# lsm_sequencer

Parametrised load-multiple / store-multiple sequencer for the decode stage of the RISC pipeline. It detects LM/SM instructions whose register mask has two or more bits set, freezes the upstream pipeline, and emits one register transfer per accepted cycle with an incrementing memory address. Single-register and empty-mask LM/SM instructions pass through to the normal datapath unchanged. It extends the combinational LM/SM stall/mux decode with configurable mask width, ordered multi-cycle sequencing, flow control and abort.

## Interface
Parameters:
- `NREGS`, 8: width of the register mask taken from `ir[NREGS-1:0]`; legal range 2..12.
- `REG_IDX_W`, 3: width of the register index; must satisfy 2^REG_IDX_W >= NREGS.
- `ADDR_W`, 16: width of the memory address.
- `OPC_LM`, 4'b0110: `ir[15:12]` value for load-multiple.
- `OPC_SM`, 4'b0111: `ir[15:12]` value for store-multiple.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ir`  in  16  instruction in decode.
- `ir_valid`  in  1  `ir` holds a valid instruction this cycle.
- `base_addr`  in  ADDR_W  start address, sampled together with `ir`.
- `advance`  in  1  downstream accepts the current transfer.
- `flush`  in  1  synchronous abort of the sequence in progress.
- `stall`  out  1  freeze fetch/decode.
- `mux_control`  out  1  selects the sequencer as the register-index/address source.
- `xfer_valid`  out  1  `xfer_*` fields are valid.
- `xfer_is_load`  out  1  1 = LM, 0 = SM.
- `xfer_reg`  out  REG_IDX_W  register index of the current transfer.
- `xfer_addr`  out  ADDR_W  memory address of the current transfer.
- `last`  out  1  current transfer is the final one.
- `busy`  out  1  sequencer is in RUN.

## Operation
- `multi`: `ir_valid`, `ir[15:12]` equal to `OPC_LM` or `OPC_SM`, and popcount(`ir[NREGS-1:0]`) >= 2. This is combinational.
- States: IDLE and RUN.
- IDLE:
  - `busy`, `mux_control`, `xfer_valid` and `last` are 0.
  - If `multi` is true at the clock edge: latch `remaining` = mask, `addr` = `base_addr`, and `is_load` = (opcode == `OPC_LM`); then go to RUN.
  - If `multi` is false, stay in IDLE. Masks with 0 or 1 bit set never start a sequence.
- RUN:
  - `busy`, `mux_control` and `xfer_valid` are 1.
  - `xfer_reg` is the index of the lowest set bit of `remaining`; the priority encoder is combinational from registered state.
  - `xfer_addr` = `addr`; `xfer_is_load` = `is_load`.
  - `last` = 1 when exactly one bit of `remaining` is set.
  - On an edge with `advance`=1: clear the lowest set bit, set `addr` = `addr` + 1 modulo 2^ADDR_W (wraps from all-ones to 0). If `last` was 1, go to IDLE.
  - On an edge with `advance`=0: all state holds and outputs stay stable.
  - `ir_valid` and `ir` are ignored in RUN.
- `flush`=1 at an edge in RUN: go to IDLE and clear `remaining`. `flush` has priority over `advance`. `flush` in IDLE has no effect and also blocks entry to RUN in the same cycle.
- `stall` = `busy` OR (`multi` AND NOT `flush`). It asserts combinationally in the decode cycle and stays high through the last transfer.
- Reset (`rst`=0), at any time including mid-sequence: go to IDLE immediately. `remaining`=0, `addr`=0, `is_load`=0. Every output is 0; `stall` is forced to 0 while `rst`=0.

## Timing
- Decode cycle D: `stall`=1 combinationally. At the edge ending D, the sequencer enters RUN.
- First transfer appears in cycle D+1. Decode-to-first-transfer latency is 1 cycle.
- With `advance` held high, a mask of N set bits gives N consecutive transfer cycles (D+1..D+N). `busy` is low again in D+N+1, and `stall` is low there unless a new `multi` is present.
- Each low cycle of `advance` adds exactly one cycle; no transfer is skipped or duplicated.
- A new LM/SM can be accepted in the first cycle after returning to IDLE, giving back-to-back sequences.
- Transfers are issued in ascending register index order and ascending address order.

## Test plan
- LM, `ir`=16'h60FF, `base_addr`=16'h0100, `advance`=1: 8 transfers, regs 0..7, addrs 0100..0107, `last` only on reg 7, `stall` high for cycles D..D+8, `busy` low at D+9.
- SM, `ir`=16'h7085, `base_addr`=16'h0020, `advance` toggling 1,0,1,0,1: regs 0,2,7 at addrs 0020,0021,0022; `xfer_is_load`=0; outputs stable during `advance`=0 cycles.
- LM `ir`=16'h6010 and LM `ir`=16'h6000: `stall`=0, `mux_control`=0, `busy` stays 0; non-LM/SM opcode with mask 16'h00FF: no stall.
- `base_addr`=16'hFFFE, mask 8'h07: addrs FFFE, FFFF, 0000; exactly 3 transfers.
- Mask 8'hFF: assert `flush` on transfer 3 → IDLE next cycle, no further transfers. Repeat with `rst` low mid-sequence → all outputs 0 immediately, IDLE after release.
- `NREGS`=12, `REG_IDX_W`=4, mask 12'h801: regs 0 and 11, 2 transfers.
